// File: rtl/alu_ops_pkg.sv
// rtl/alu_ops_pkg.sv - opcode constants and sequencer state type for the serial ALU
package alu_ops_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage : alu_ops_pkg

// File: rtl/alu_1bit_msb.sv
// rtl/alu_1bit_msb.sv - 1-bit ALU slice with MSB extras (overflow, set)
module alu_1bit_msb
    import alu_ops_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       binvert_i,
    input  logic       carry_in_i,
    input  logic       less_i,
    input  logic [2:0] op_i,
    output logic       result_o,
    output logic       carry_out_o,
    output logic       overflow_o,
    output logic       set_o
);

    logic b_eff;
    logic sum;

    assign b_eff       = b_i ^ binvert_i;
    assign sum         = a_i ^ b_eff ^ carry_in_i;
    assign carry_out_o = (a_i & b_eff) | (carry_in_i & (a_i ^ b_eff));
    // At the MSB, signed overflow is a mismatch between carry into and out of the bit.
    assign overflow_o  = carry_in_i ^ carry_out_o;
    // Raw sign of the sum; SLT uses it without overflow correction.
    assign set_o       = sum;

    // Select the slice output; any opcode outside AND/OR/SLT yields the adder sum.
    always_comb begin
        result_o = sum;
        case (op_i)
            OP_AND:  result_o = a_i & b_eff;
            OP_OR:   result_o = a_i | b_eff;
            OP_SLT:  result_o = less_i;
            default: result_o = sum;
        endcase
    end

endmodule : alu_1bit_msb

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial ALU sequencer, LSB first through one 1-bit slice
module alu_serial_seq
    import alu_ops_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    seq_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic [WIDTH-1:0] result_q;
    logic [2:0]       op_q;
    logic             carry_q;
    logic             done_q;
    logic             zero_q;
    logic             ovf_q;
    logic             cout_q;

    logic             s_result;
    logic             s_carry_out;
    logic             s_overflow;
    logic             s_set;

    logic [WIDTH-1:0] res_sh_d;
    logic [WIDTH-1:0] result_d;
    logic             last_bit;
    logic             is_addsub;

    alu_1bit_msb u_slice (
        .a_i         (a_sh_q[0]),
        .b_i         (b_sh_q[0]),
        .binvert_i   (op_q[2]),
        .carry_in_i  (carry_q),
        .less_i      (1'b0),
        .op_i        (op_q),
        .result_o    (s_result),
        .carry_out_o (s_carry_out),
        .overflow_o  (s_overflow),
        .set_o       (s_set)
    );

    // Next shift-register value and the final result as seen on the last RUN bit,
    // so result/flags are already valid in the cycle done is high.
    always_comb begin
        res_sh_d  = {s_result, res_sh_q[WIDTH-1:1]};
        result_d  = res_sh_d;
        if (op_q == OP_SLT) begin
            result_d = {{(WIDTH-1){1'b0}}, s_set};
        end
        last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
        is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
    end

    // Sequencer: accept in IDLE, one bit per cycle in RUN, one-cycle DONE pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            result_q <= '0;
            op_q     <= OP_AND;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        op_q    <= op;
                        carry_q <= op[2];
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    carry_q  <= s_carry_out;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    res_sh_q <= res_sh_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        result_q <= result_d;
                        zero_q   <= (result_d == '0);
                        ovf_q    <= is_addsub & s_overflow;
                        cout_q   <= s_carry_out;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;

endmodule : alu_serial_seq
